// File: rtl/ps2_receiver.sv
// ps2_receiver: synchronises and glitch-filters the PS/2 pins, then deserialises and validates 11-bit frames.
// Accepted bytes are kept in a 4-byte history; per-frame accept/reject strobes last one cycle.
module ps2_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        PS2_CLK,
   input  logic        PS2_DAT,
   output logic [31:0] received_data,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   output logic        frame_error
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   logic [1:0]    clk_s, dat_s;
   logic          fclk, fall;
   logic [FW-1:0] fcnt;
   logic [1:0]    state;
   logic [2:0]    cnt;
   logic [7:0]    sh;
   logic          par;
   logic [TW-1:0] tcnt;
   logic          dat;

   assign dat = dat_s[1];

   // fall is registered alongside fclk, so it is high exactly in the first cycle fclk reads 0
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         clk_s <= 2'b11;
         dat_s <= 2'b11;
         fclk  <= 1'b1;
         fcnt  <= '0;
         fall  <= 1'b0;
      end else begin
         clk_s <= {clk_s[0], PS2_CLK};
         dat_s <= {dat_s[0], PS2_DAT};
         fall  <= 1'b0;
         if (clk_s[1] == fclk)
            fcnt <= '0;
         else if (fcnt == FW'(FILTER_LEN - 1)) begin
            fclk <= clk_s[1];
            fcnt <= '0;
            fall <= fclk;
         end else
            fcnt <= fcnt + 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         sh            <= '0;
         par           <= 1'b0;
         tcnt          <= '0;
         received_data <= '0;
         byte_data     <= '0;
         byte_valid    <= 1'b0;
         frame_error   <= 1'b0;
      end else begin
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
         tcnt        <= (fall || state == IDLE) ? '0 : tcnt + 1'b1;
         if (fall) begin
            case (state)
               IDLE: if (!dat) begin
                  state <= DATA;
                  cnt   <= '0;
               end
               DATA: begin
                  sh  <= {dat, sh[7:1]};
                  cnt <= cnt + 1'b1;
                  if (cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par   <= dat;
                  state <= STOP;
               end
               default: begin
                  state <= IDLE;
                  if (dat && (^sh ^ par)) begin
                     byte_data     <= sh;
                     received_data <= {received_data[23:0], sh};
                     byte_valid    <= 1'b1;
                  end else
                     frame_error <= 1'b1;
               end
            endcase
         end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state       <= IDLE;
            frame_error <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: directed PS/2 frames with hand-computed expected history and strobe counts.
module tb_ps2_receiver;
   localparam int FL = 8;
   localparam int TO = 300;
   localparam int H  = 40;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_dat = 1'b1;
   logic [31:0] received_data;
   logic [7:0]  byte_data;
   logic        byte_valid, frame_error;

   int checks = 0, errors = 0;
   int nv = 0, ne = 0, nf = 0, nboth = 0, cyc = 0, last_fall = 0, last_err = 0;
   int v0, e0, f0;

   ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .CLOCK_50(clk), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
      .received_data(received_data), .byte_data(byte_data),
      .byte_valid(byte_valid), .frame_error(frame_error)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (byte_valid) nv++;
      if (frame_error) begin
         ne++;
         last_err = cyc;
      end
      if (byte_valid && frame_error) nboth++;
      if (dut.fall) begin
         nf++;
         last_fall = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   // nbits < 11 truncates the frame; glitch_bit >= 0 adds a 5-cycle clock low pulse before that bit's fall
   task automatic send(input logic [7:0] b, input bit bad_par, input bit stop_bit,
                       input int nbits, input int glitch_bit);
      logic [10:0] fr;
      fr = {stop_bit, ~^b ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = fr[i];
         wait_cyc(H);
         if (i == glitch_bit) begin
            ps2_clk = 1'b0;
            wait_cyc(5);
            ps2_clk = 1'b1;
            wait_cyc(H);
         end
         ps2_clk = 1'b0;
         wait_cyc(H);
         ps2_clk = 1'b1;
      end
      wait_cyc(H);
      ps2_dat = 1'b1;
   endtask

   task automatic snap;
      v0 = nv;
      e0 = ne;
      f0 = nf;
   endtask

   initial begin
      wait_cyc(3);
      @(negedge clk);
      check("rst_received", received_data, 32'h0);
      check("rst_byte", {24'h0, byte_data}, 32'h0);
      check("rst_valid", {31'h0, byte_valid}, 32'h0);
      check("rst_error", {31'h0, frame_error}, 32'h0);
      reset = 1'b0;
      wait_cyc(5);

      snap();
      send(8'h1C, 1'b0, 1'b1, 11, -1);
      check("v1_valid_cnt", nv - v0, 1);
      check("v1_error_cnt", ne - e0, 0);
      check("v1_fall_cnt", nf - f0, 11);
      check("v1_byte", {24'h0, byte_data}, 32'h1C);
      check("v1_received", received_data, 32'h0000001C);

      send(8'hF0, 1'b0, 1'b1, 11, -1);
      send(8'h1C, 1'b0, 1'b1, 11, -1);
      send(8'h32, 1'b0, 1'b1, 11, -1);
      send(8'h5A, 1'b0, 1'b1, 11, -1);
      check("seq_valid_cnt", nv - v0, 5);
      check("seq_received", received_data, 32'hF01C325A);
      check("seq_byte", {24'h0, byte_data}, 32'h5A);

      snap();
      send(8'h1C, 1'b1, 1'b1, 11, -1);
      check("par_error_cnt", ne - e0, 1);
      check("par_valid_cnt", nv - v0, 0);
      check("par_received", received_data, 32'hF01C325A);
      send(8'h1C, 1'b0, 1'b0, 11, -1);
      check("stop_error_cnt", ne - e0, 2);
      check("stop_valid_cnt", nv - v0, 0);
      check("stop_received", received_data, 32'hF01C325A);
      check("stop_byte", {24'h0, byte_data}, 32'h5A);

      snap();
      send(8'h1C, 1'b0, 1'b1, 5, -1);
      wait_cyc(TO + 10);
      check("to_error_cnt", ne - e0, 1);
      check("to_latency", last_err - last_fall, TO + 1);
      check("to_received", received_data, 32'hF01C325A);
      send(8'h5A, 1'b0, 1'b1, 11, -1);
      check("to_next_valid", nv - v0, 1);
      check("to_next_received", received_data, 32'h1C325A5A);

      snap();
      send(8'h1C, 1'b0, 1'b1, 11, 4);
      check("gl_fall_cnt", nf - f0, 11);
      check("gl_valid_cnt", nv - v0, 1);
      check("gl_error_cnt", ne - e0, 0);
      check("gl_received", received_data, 32'h325A5A1C);

      snap();
      ps2_dat = 1'b1;
      wait_cyc(H);
      ps2_clk = 1'b0;
      wait_cyc(H);
      ps2_clk = 1'b1;
      wait_cyc(H);
      check("idle_fall_cnt", nf - f0, 1);
      check("idle_valid_cnt", nv - v0, 0);
      check("idle_error_cnt", ne - e0, 0);

      snap();
      send(8'h1C, 1'b0, 1'b1, 7, -1);
      reset = 1'b1;
      wait_cyc(3);
      @(negedge clk);
      check("mid_rst_received", received_data, 32'h0);
      check("mid_rst_byte", {24'h0, byte_data}, 32'h0);
      reset = 1'b0;
      wait_cyc(5);
      check("mid_rst_strobes", (nv - v0) + (ne - e0), 0);
      send(8'h1C, 1'b0, 1'b1, 11, -1);
      check("post_rst_valid", nv - v0, 1);
      check("post_rst_received", received_data, 32'h0000001C);
      check("post_rst_byte", {24'h0, byte_data}, 32'h1C);

      check("never_both", nboth, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
